// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - PC sequencer: fetch handshake, retire/jump selection, halt/resume, fetch watchdog
// Optional breakpoint comparator enabled by defining PC_SEQ_BREAKPOINT_EN.
module pc_seq_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32,
    localparam int PC_OP_LEN  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic                 dec_valid,
    input  logic [2:0]           dec_kind,
    input  logic                 br_taken,
    input  logic                 stall,
    input  logic                 resume,
`ifdef PC_SEQ_BREAKPOINT_EN
    input  logic                 bp_en,
    input  logic [31:0]          bp_addr,
`endif
    output logic [PC_OP_LEN-1:0] pc_op,
    output logic                 instr_fire,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_W-1:0]     instret
);

    localparam logic [PC_OP_LEN-1:0] PC_OP_HALT       = 3'd0;
    localparam logic [PC_OP_LEN-1:0] PC_OP_NEXT_STEP  = 3'd1;
    localparam logic [PC_OP_LEN-1:0] PC_OP_IMM_JMP    = 3'd2;
    localparam logic [PC_OP_LEN-1:0] PC_OP_OFFSET_JMP = 3'd3;
    localparam logic [PC_OP_LEN-1:0] PC_OP_REG_JMP    = 3'd4;

    localparam logic [2:0] K_J    = 3'd1;
    localparam logic [2:0] K_BR   = 3'd2;
    localparam logic [2:0] K_JR   = 3'd3;
    localparam logic [2:0] K_HALT = 3'd4;

    localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
    localparam int WD_W   = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_HALTED} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [BOOT_W-1:0] r_boot_cnt;
    logic [WD_W-1:0]   r_wd;
    logic              r_fault;
    logic [CNT_W-1:0]  r_instret;

    logic w_boot_done;
    logic w_wd_expire;
    logic w_retire;
    logic w_bp_hit;

    assign w_boot_done = (r_boot_cnt == BOOT_W'(BOOT_CYCLES - 1));
    assign w_wd_expire = (r_wd == WD_W'(MEM_TIMEOUT - 1)) && !imem_ready;
    assign w_retire    = (r_state == S_EXEC) && dec_valid && !stall;

`ifdef PC_SEQ_BREAKPOINT_EN
    // The skip flag lets the fetch right after a resume pass the breakpoint once.
    logic r_bp_skip;
    assign w_bp_hit = (r_state == S_FETCH) && bp_en && (pc == bp_addr) && !r_bp_skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bp_skip <= 1'b0;
        end else if (r_state == S_HALTED && resume && !r_fault) begin
            r_bp_skip <= 1'b1;
        end else if (r_state == S_FETCH && (imem_ready || w_wd_expire)) begin
            r_bp_skip <= 1'b0;
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^pc;
    assign w_bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT: begin
                if (w_boot_done) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_bp_hit)         w_state_next = S_HALTED;
                else if (imem_ready)  w_state_next = S_EXEC;
                else if (w_wd_expire) w_state_next = S_HALTED;
            end
            S_EXEC: begin
                if (w_retire) w_state_next = (dec_kind == K_HALT) ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                if (resume && !r_fault) w_state_next = S_FETCH;
            end
            default: w_state_next = S_BOOT;
        endcase
    end

    always_comb begin
        imem_req   = (r_state == S_FETCH) && !w_bp_hit;
        halted     = (r_state == S_HALTED);
        instr_fire = w_retire;
        pc_op      = PC_OP_HALT;
        if (w_retire) begin
            case (dec_kind)
                K_J:     pc_op = PC_OP_IMM_JMP;
                K_BR:    pc_op = br_taken ? PC_OP_OFFSET_JMP : PC_OP_NEXT_STEP;
                K_JR:    pc_op = PC_OP_REG_JMP;
                K_HALT:  pc_op = PC_OP_HALT;
                default: pc_op = PC_OP_NEXT_STEP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_boot_cnt <= '0;
        end else if (r_state == S_BOOT && !w_boot_done) begin
            r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
        end
    end

    // Watchdog only runs while a request is actually outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (r_state == S_FETCH && !imem_ready && !w_bp_hit) begin
            r_wd <= r_wd + WD_W'(1);
        end else begin
            r_wd <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (r_state == S_FETCH && w_wd_expire && !w_bp_hit) begin
            r_fault <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign fault   = r_fault;
    assign instret = r_instret;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - directed self-checking bench for pc_seq_ctrl
module tb_pc_seq_ctrl;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_NEXT = 3'd1;
    localparam logic [2:0] OP_IMM  = 3'd2;
    localparam logic [2:0] OP_OFF  = 3'd3;
    localparam logic [2:0] OP_REG  = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_req;
    logic        imem_ready;
    logic        dec_valid;
    logic [2:0]  dec_kind;
    logic        br_taken;
    logic        stall;
    logic        resume;
    logic [2:0]  pc_op;
    logic        instr_fire;
    logic        halted;
    logic        fault;
    logic [31:0] instret;

    int n_chk  = 0;
    int n_fail = 0;

    pc_seq_ctrl #(
        .BOOT_CYCLES (2),
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .dec_valid  (dec_valid),
        .dec_kind   (dec_kind),
        .br_taken   (br_taken),
        .stall      (stall),
        .resume     (resume),
        .pc_op      (pc_op),
        .instr_fire (instr_fire),
        .halted     (halted),
        .fault      (fault),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH with imem_ready=1; leaves in the following FETCH.
    task automatic run_instr(input logic [2:0] kind, input logic tk, input logic [2:0] exp_op, input string tag);
        dec_kind = kind;
        br_taken = tk;
        step();
        chk(tag, 32'(pc_op), 32'(exp_op));
        chk({tag, "_fire"}, 32'(instr_fire), 32'd1);
        step();
    endtask

    initial begin
        rst        = 1'b1;
        pc         = 32'h100;
        imem_ready = 1'b0;
        dec_valid  = 1'b0;
        dec_kind   = 3'd0;
        br_taken   = 1'b0;
        stall      = 1'b0;
        resume     = 1'b0;
        step();
        step();
        chk("rst_req",     32'(imem_req),   32'd0);
        chk("rst_fire",    32'(instr_fire), 32'd0);
        chk("rst_halted",  32'(halted),     32'd0);
        chk("rst_fault",   32'(fault),      32'd0);
        chk("rst_instret", instret,         32'd0);
        chk("rst_pcop",    32'(pc_op),      32'(OP_HALT));

        imem_ready = 1'b1;
        dec_valid  = 1'b1;
        rst        = 1'b0;
        #1;
        chk("boot_c1_req", 32'(imem_req), 32'd0);
        step();
        chk("boot_c2_req", 32'(imem_req), 32'd0);
        step();
        chk("c3_req", 32'(imem_req), 32'd1);

        for (int i = 0; i < 10; i++) begin
            chk("seq_fetch_pcop", 32'(pc_op),    32'(OP_HALT));
            chk("seq_fetch_req",  32'(imem_req), 32'd1);
            step();
            chk("seq_exec_pcop",  32'(pc_op),      32'(OP_NEXT));
            chk("seq_exec_fire",  32'(instr_fire), 32'd1);
            chk("seq_exec_req",   32'(imem_req),   32'd0);
            step();
        end
        chk("instret_10", instret, 32'd10);

        run_instr(3'd2, 1'b1, OP_OFF,  "br_taken");
        run_instr(3'd2, 1'b0, OP_NEXT, "br_not_taken");
        run_instr(3'd1, 1'b0, OP_IMM,  "jmp_imm");
        run_instr(3'd3, 1'b0, OP_REG,  "jmp_reg");
        run_instr(3'd6, 1'b1, OP_NEXT, "kind6_seq");
        chk("instret_15", instret, 32'd15);

        dec_kind = 3'd0;
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pcop", 32'(pc_op),      32'(OP_HALT));
            chk("stall_fire", 32'(instr_fire), 32'd0);
        end
        stall = 1'b0;
        #1;
        chk("stall_rel_pcop",    32'(pc_op),      32'(OP_NEXT));
        chk("stall_rel_fire",    32'(instr_fire), 32'd1);
        chk("stall_rel_instret", instret,         32'd15);
        step();
        chk("stall_instret_16", instret,          32'd16);
        chk("stall_back_fetch", 32'(imem_req),    32'd1);

        dec_kind = 3'd4;
        step();
        chk("halt_instr_pcop", 32'(pc_op),      32'(OP_HALT));
        chk("halt_instr_fire", 32'(instr_fire), 32'd1);
        step();
        dec_kind = 3'd0;
        for (int i = 0; i < 3; i++) begin
            chk("halted_flag", 32'(halted),   32'd1);
            chk("halted_pcop", 32'(pc_op),    32'(OP_HALT));
            chk("halted_req",  32'(imem_req), 32'd0);
            step();
        end
        chk("halt_instret_17", instret, 32'd17);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_halted", 32'(halted),   32'd0);
        chk("resume_req",    32'(imem_req), 32'd1);
        step();
        chk("resume_exec_fire", 32'(instr_fire), 32'd1);
        step();
        chk("instret_18", instret, 32'd18);

        imem_ready = 1'b0;
        dec_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_req",   32'(imem_req), 32'd1);
            chk("to_wait_fault", 32'(fault),    32'd0);
            step();
        end
        chk("to_fault",  32'(fault),    32'd1);
        chk("to_halted", 32'(halted),   32'd1);
        chk("to_req",    32'(imem_req), 32'd0);
        resume = 1'b1;
        step();
        step();
        resume = 1'b0;
        chk("to_resume_ign_halted", 32'(halted),   32'd1);
        chk("to_resume_ign_req",    32'(imem_req), 32'd0);
        rst = 1'b1;
        #1;
        chk("to_rst_fault",   32'(fault),  32'd0);
        chk("to_rst_halted",  32'(halted), 32'd0);
        chk("to_rst_instret", instret,     32'd0);

        step();
        rst = 1'b0;
        step();
        step();
        chk("mid_fetch_req", 32'(imem_req), 32'd1);
        #2;
        rst        = 1'b1;
        imem_ready = 1'b1;
        dec_valid  = 1'b1;
        #1;
        chk("mid_rst_req",     32'(imem_req),   32'd0);
        chk("mid_rst_pcop",    32'(pc_op),      32'(OP_HALT));
        chk("mid_rst_fire",    32'(instr_fire), 32'd0);
        chk("mid_rst_halted",  32'(halted),     32'd0);
        chk("mid_rst_fault",   32'(fault),      32'd0);
        chk("mid_rst_instret", instret,         32'd0);
        step();
        chk("mid_rst_hold_req",  32'(imem_req),   32'd0);
        chk("mid_rst_hold_fire", 32'(instr_fire), 32'd0);

        imem_ready = 1'b0;
        rst        = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("edge_wait_req", 32'(imem_req), 32'd1);
            step();
        end
        imem_ready = 1'b1;
        #1;
        chk("edge_last_req", 32'(imem_req), 32'd1);
        step();
        chk("edge_ready_fault",  32'(fault),      32'd0);
        chk("edge_ready_halted", 32'(halted),     32'd0);
        chk("edge_ready_fire",   32'(instr_fire), 32'd1);
        step();
        chk("edge_instret_1", instret, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
